// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, op encoding and FSM state for the register-file port master
package rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  typedef enum logic [1:0] {
    OP_CLEAR      = 2'b00,
    OP_READ       = 2'b01,
    OP_WRITE      = 2'b10,
    OP_READ_WRITE = 2'b11
  } rf_op_e;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CAPT  = 2'b10,
    RESP  = 2'b11
  } rf_state_e;
endpackage

// File: rtl/rf_port_master_if.sv
// rf_port_master_if: request/response handshake bundle between a client and the port master
interface rf_port_master_if;
  import rf_pkg::*;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [RF_ADDR_W-1:0] req_raddr1;
  logic [RF_ADDR_W-1:0] req_raddr2;
  logic [RF_ADDR_W-1:0] req_waddr;
  logic [RF_DATA_W-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RF_DATA_W-1:0] rsp_data1;
  logic [RF_DATA_W-1:0] rsp_data2;
  modport master (
    output req_valid, req_op, req_raddr1, req_raddr2, req_waddr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );
  modport slave (
    input  req_valid, req_op, req_raddr1, req_raddr2, req_waddr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/rf_port_master.sv
// rf_port_master: sequences one request at a time onto an external register file; RF_BYPASS_EN selects new-data reads for READ_WRITE
module rf_port_master
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rf_port_master_if.slave      bus,
  output logic                 rf_enable,
  output logic                 rf_read_en,
  output logic                 rf_write_en,
  output logic                 rf_reset,
  output logic [RF_ADDR_W-1:0] rf_read_addr1,
  output logic [RF_ADDR_W-1:0] rf_read_addr2,
  output logic [RF_ADDR_W-1:0] rf_write_addr,
  output logic [RF_DATA_W-1:0] rf_data,
  input  logic [RF_DATA_W-1:0] rf_read_out1,
  input  logic [RF_DATA_W-1:0] rf_read_out2
);
  rf_state_e            state, state_nx;
  rf_op_e               op;
  logic [RF_ADDR_W-1:0] raddr1, raddr2, waddr;
  logic [RF_DATA_W-1:0] wdata, rsp_data1, rsp_data2, rd1, rd2;
  logic                 is_read;
  assign is_read = (op == OP_READ) || (op == OP_READ_WRITE);
`ifdef RF_BYPASS_EN
  // the register file returns old data on a same-edge write, so forward the written word
  assign rd1 = (op == OP_READ_WRITE && raddr1 == waddr) ? wdata : rf_read_out1;
  assign rd2 = (op == OP_READ_WRITE && raddr2 == waddr) ? wdata : rf_read_out2;
`else
  assign rd1 = rf_read_out1;
  assign rd2 = rf_read_out2;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= OP_CLEAR;
      raddr1    <= '0;
      raddr2    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
    end else begin
      state <= state_nx;
      if (bus.req_valid && bus.req_ready) begin
        op     <= rf_op_e'(bus.req_op);
        raddr1 <= bus.req_raddr1;
        raddr2 <= bus.req_raddr2;
        waddr  <= bus.req_waddr;
        wdata  <= bus.req_wdata;
      end
      if (state == CAPT) begin
        rsp_data1 <= rd1;
        rsp_data2 <= rd2;
      end
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = bus.req_valid ? ISSUE : IDLE;
      ISSUE: state_nx = is_read ? CAPT : IDLE;
      CAPT:  state_nx = RESP;
      RESP:  state_nx = bus.rsp_ready ? IDLE : RESP;
    endcase
    bus.req_ready = reset && state == IDLE;
    bus.rsp_valid = reset && state == RESP;
    rf_enable     = reset && state == ISSUE;
    rf_read_en    = rf_enable && is_read;
    rf_write_en   = rf_enable && (op == OP_WRITE || op == OP_READ_WRITE);
    rf_reset      = !reset || (rf_enable && op == OP_CLEAR);
  end
  assign bus.rsp_data1 = rsp_data1;
  assign bus.rsp_data2 = rsp_data2;
  assign rf_read_addr1 = raddr1;
  assign rf_read_addr2 = raddr2;
  assign rf_write_addr = waddr;
  assign rf_data       = wdata;
endmodule

// File: tb/tb_rf_port_master.sv
// tb_rf_port_master: directed bench for rf_port_master with a behavioural register file attached
module tb_rf_port_master;
  logic        clk = 0;
  logic        reset = 0;
  logic        rf_enable, rf_read_en, rf_write_en, rf_reset;
  logic [4:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [31:0] rf_data, rf_read_out1, rf_read_out2;
  logic [31:0] mem [32];
  int          n_chk = 0;
  int          n_pass = 0;
  rf_port_master_if bus ();
  rf_port_master dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_enable(rf_enable), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_reset(rf_reset),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2), .rf_write_addr(rf_write_addr),
    .rf_data(rf_data), .rf_read_out1(rf_read_out1), .rf_read_out2(rf_read_out2)
  );
  always #5 clk = ~clk;
  // register file: synchronous read of old contents, write on the same edge
  always @(posedge clk) begin
    if (rf_reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_read_out1 <= '0;
      rf_read_out2 <= '0;
    end else if (rf_enable) begin
      if (rf_read_en) begin
        rf_read_out1 <= mem[rf_read_addr1];
        rf_read_out2 <= mem[rf_read_addr2];
      end
      if (rf_write_en) mem[rf_write_addr] <= rf_data;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.req_valid  = 1;
    bus.req_op     = op;
    bus.req_raddr1 = r1;
    bus.req_raddr2 = r2;
    bus.req_waddr  = wa;
    bus.req_wdata  = wd;
  endtask
  task automatic txn(input string tag, input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] e1, input logic [31:0] e2);
    drive(op, r1, r2, wa, wd);
    @(negedge clk);
    bus.req_valid = 0;
    chk({tag, "_issue_en"}, rf_enable, 1);
    chk({tag, "_issue_rd"}, rf_read_en, op == 2'b01 || op == 2'b11);
    chk({tag, "_issue_wr"}, rf_write_en, op == 2'b10 || op == 2'b11);
    chk({tag, "_issue_clr"}, rf_reset, op == 2'b00);
    chk({tag, "_issue_addr"}, {rf_read_addr1, rf_read_addr2, rf_write_addr}, {r1, r2, wa});
    chk({tag, "_issue_data"}, rf_data, wd);
    @(negedge clk);
    if (op == 2'b01 || op == 2'b11) begin
      chk({tag, "_capt_vld"}, bus.rsp_valid, 0);
      chk({tag, "_capt_en"}, rf_enable, 0);
      @(negedge clk);
      chk({tag, "_rsp_vld"}, bus.rsp_valid, 1);
      chk({tag, "_rsp_d1"}, bus.rsp_data1, e1);
      chk({tag, "_rsp_d2"}, bus.rsp_data2, e2);
      chk({tag, "_rsp_rdy"}, bus.req_ready, 0);
      bus.rsp_ready = 1;
      @(negedge clk);
      bus.rsp_ready = 0;
      chk({tag, "_done_vld"}, bus.rsp_valid, 0);
    end else begin
      chk({tag, "_done_en"}, rf_enable, 0);
      chk({tag, "_done_clr"}, rf_reset, 0);
      chk({tag, "_done_hold"}, rf_write_addr, wa);
    end
    chk({tag, "_done_rdy"}, bus.req_ready, 1);
  endtask
  initial begin
    logic [31:0] rw_exp;
    bus.req_valid = 0;
    bus.rsp_ready = 0;
    drive(2'b00, 0, 0, 0, 0);
    bus.req_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.req_ready, 0);
    chk("rst_rfclr", rf_reset, 1);
    chk("rst_vld", bus.rsp_valid, 0);
    chk("rst_d1", bus.rsp_data1, 0);
    chk("rst_en", {rf_enable, rf_read_en, rf_write_en}, 0);
    reset = 1;
    @(negedge clk);
    chk("rel_rdy", bus.req_ready, 1);
    chk("rel_rfclr", rf_reset, 0);
    txn("wr5", 2'b10, 0, 0, 5, 32'hDEADBEEF, 0, 0);
    txn("rd5", 2'b01, 5, 0, 0, 0, 32'hDEADBEEF, 0);
`ifdef RF_BYPASS_EN
    rw_exp = 32'h12345678;
`else
    rw_exp = 32'hDEADBEEF;
`endif
    txn("rw5", 2'b11, 5, 0, 5, 32'h12345678, rw_exp, 0);
    txn("rd5b", 2'b01, 5, 0, 0, 0, 32'h12345678, 0);
    txn("wr0", 2'b10, 0, 0, 0, 32'h11111111, 0, 0);
    txn("rd0", 2'b01, 5, 0, 0, 0, 32'h12345678, 32'h11111111);
    drive(2'b01, 5, 0, 0, 0);
    repeat (3) @(negedge clk);
    bus.req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_vld", bus.rsp_valid, 1);
      chk("stall_d1", bus.rsp_data1, 32'h12345678);
      chk("stall_rdy", bus.req_ready, 0);
      if (i == 0) drive(2'b10, 0, 0, 5, 32'h0);
      @(negedge clk);
    end
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    chk("stall_idle", bus.req_ready, 1);
    chk("stall_novld", bus.rsp_valid, 0);
    txn("rd5c", 2'b01, 5, 0, 0, 0, 32'h12345678, 32'h11111111);
    txn("wr31", 2'b10, 0, 0, 31, 32'hA5A5A5A5, 0, 0);
    txn("rd31", 2'b01, 31, 5, 0, 0, 32'hA5A5A5A5, 32'h12345678);
    txn("clr", 2'b00, 0, 0, 0, 0, 0, 0);
    txn("rd31c", 2'b01, 31, 5, 0, 0, 0, 0);
    txn("wr7", 2'b10, 0, 0, 7, 32'h0BADF00D, 0, 0);
    drive(2'b01, 7, 7, 0, 0);
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_rst_vld", bus.rsp_valid, 0);
    chk("mid_rst_clr", rf_reset, 1);
    chk("mid_rst_rdy", bus.req_ready, 0);
    @(negedge clk);
    chk("mid_rst_d", {bus.rsp_data1, bus.rsp_data2}, 0);
    chk("mid_rst_lat", {rf_read_addr1, rf_read_addr2, rf_write_addr, rf_data}, 0);
    chk("mid_rst_en", {rf_enable, rf_read_en, rf_write_en}, 0);
    reset = 1;
    @(negedge clk);
    chk("mid_rel_rdy", bus.req_ready, 1);
    chk("mid_rel_vld", bus.rsp_valid, 0);
    txn("rd7", 2'b01, 7, 5, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
